// File: rtl/ifetch.sv
// Generic synchronous FIFO with flush, used as the ifetch prefetch buffer.
// Latency: a pushed entry reaches the head one cycle after the push; no bypass.
// Backpressure: the caller never pushes when full or pops when empty; flush beats push/pop.
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
endmodule

// Instruction fetch: keeps the fetch PC, issues word reads, buffers {pc, word} for execute.
// Latency: grant in T, rvalid in T+L gives ins_valid in T+L+1; redirect empties the head next cycle.
// Backpressure: requests need a credit (cnt + out < DEPTH); ins_ready low simply holds the head.
module ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  logic [31:0] fpc;
  logic [31:0] rpc;
  logic [CW-1:0] out;
  logic [CW-1:0] kill;
  logic [CW-1:0] cnt;
  logic [CW-1:0] out_next;
  logic [CW:0]   used;
  logic [31:0]   target;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          pop;
  entry_t        push_ent;
  entry_t        head;
  logic          unused;

  assign unused = &{1'b0, redirect_pc[1:0]};
  assign target = {redirect_pc[31:2], 2'b00};

  // Every live in-flight request owns a FIFO slot, so a push can never overflow.
  assign used     = {1'b0, cnt} + {1'b0, out};
  assign imem_req = !rst && !redirect && (used < (CW+1)'(DEPTH));
  assign imem_addr = fpc;

  assign grant    = imem_req && imem_gnt;
  assign rsp      = imem_rvalid && (out != '0);
  assign push     = rsp && (kill == '0) && !redirect;
  assign pop      = ins_valid && ins_ready && !redirect;
  assign out_next = out + CW'(grant) - CW'(rsp);

  assign push_ent = '{pc: rpc, word: imem_rdata};

  ifetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (push_ent),
    .rdata (head),
    .count (cnt)
  );

  assign ins_valid = !rst && (cnt != '0);
  assign ins       = ins_valid ? head.word : '0;
  assign ins_pc    = ins_valid ? head.pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc  <= RESET_PC;
      rpc  <= RESET_PC;
      out  <= '0;
      kill <= '0;
    end else begin
      out <= out_next;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        fpc  <= target;
        rpc  <= target;
        kill <= out_next;
      end else begin
        if (grant) begin
          fpc <= fpc + 32'd4;
        end
        if (rsp) begin
          if (kill != '0) begin
            kill <= kill - 1'b1;
          end else begin
            rpc <= rpc + 32'd4;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: pipelined memory model, tagged-request reference model, directed + random phases.
`timescale 1ns/1ps
module tb_ifetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  ifetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ins_valid   (ins_valid),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_ready   (ins_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction memory: in-order responses, each at least lat cycles after its grant.
  int unsigned cyc_n = 0;
  int unsigned lat = 1;
  bit          lat_rand = 0;
  bit          gnt_rand = 0;
  bit          gnt_fix = 1;
  int          stray_n = 0;
  logic [31:0] mq_addr[$];
  int unsigned mq_due[$];
  int unsigned last_due = 0;
  int unsigned mdue;

  always @(posedge clk) begin
    #2;
    cyc_n++;
    imem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_fix;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (stray_n > 0) begin
      stray_n--;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (mq_due.size() > 0 && mq_due[0] <= cyc_n) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      last_due = cyc_n;
    end else if (imem_req && imem_gnt) begin
      mdue = cyc_n + (lat_rand ? $urandom_range(1, 4) : lat);
      if (mdue <= last_due) mdue = last_due + 1;
      mq_addr.push_back(imem_addr);
      mq_due.push_back(mdue);
      last_due = mdue;
    end
  end

  // Reference model: buffered PCs plus in-flight requests tagged with their PC and a live flag.
  logic [31:0] m_fifo[$];
  logic [31:0] m_fl_pc[$];
  bit          m_fl_live[$];
  logic [31:0] m_fpc = RESET_PC;
  logic [31:0] r_pc;
  bit          r_live;
  bit          r_hit;
  bit          e_req;
  bit          e_valid;

  always @(negedge clk) begin
    e_req   = !rst && !redirect && (m_fifo.size() + m_fl_pc.size() < DEPTH);
    e_valid = !rst && (m_fifo.size() > 0);
    check("imem_req", imem_req, e_req);
    if (e_req) check("imem_addr", imem_addr, m_fpc);
    check("ins_valid", ins_valid, e_valid);
    if (e_valid) begin
      check("ins_pc", ins_pc, m_fifo[0]);
      check("ins", ins, memf(m_fifo[0]));
    end else begin
      check("ins_pc_idle", ins_pc, 32'h0);
      check("ins_idle", ins, 32'h0);
    end

    if (rst) begin
      m_fifo.delete();
      m_fl_pc.delete();
      m_fl_live.delete();
      m_fpc = RESET_PC;
    end else begin
      r_hit = imem_rvalid && (m_fl_pc.size() > 0);
      r_pc = '0;
      r_live = 0;
      if (r_hit) begin
        r_pc   = m_fl_pc.pop_front();
        r_live = m_fl_live.pop_front();
      end
      if (redirect) begin
        m_fifo.delete();
        for (int i = 0; i < m_fl_live.size(); i++) m_fl_live[i] = 0;
        m_fpc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (e_req && imem_gnt) begin
          m_fl_pc.push_back(m_fpc);
          m_fl_live.push_back(1'b1);
          m_fpc = m_fpc + 32'd4;
        end
        if (e_valid && ins_ready) void'(m_fifo.pop_front());
        if (r_hit && r_live) m_fifo.push_back(r_pc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      rst = 1'b1;
      redirect = 1'b0;
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc();
      @(negedge clk);
      if (ins_valid) ok = 1;
    end
    check(name, ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int ngr;

  initial begin
    // Zero-wait memory, consumer always ready.
    ins_ready = 1'b1; gnt_fix = 1'b1; lat = 1;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", ins_valid, 0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    check("a_req0", imem_req, 1);
    check("a_addr0", imem_addr, RESET_PC);
    check("a_valid0", ins_valid, 0);
    cyc(); @(negedge clk);
    check("a_valid1", ins_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk);
      check("a_valid_seq", ins_valid, 1);
      check("a_pc_seq", ins_pc, 32'(i * 4));
    end

    // Stalled consumer: credits run out after DEPTH grants, then drain in order.
    ins_ready = 1'b0;
    do_reset(2);
    ngr = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      if (imem_req && imem_gnt) ngr++;
    end
    check("b_grants", ngr, 4);
    check("b_req_stalled", imem_req, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); ins_ready = 1'b1;
      @(negedge clk);
      check("b_drain_valid", ins_valid, 1);
      check("b_drain_pc", ins_pc, 32'(i * 4));
    end

    // L=3: redirect with one buffered entry and two requests in flight.
    ins_ready = 1'b0; lat = 3; gnt_fix = 1'b1;
    do_reset(2);
    cyc(); cyc();
    cyc(); gnt_fix = 1'b0;
    cyc(); redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    check("c_valid_at_redirect", ins_valid, 1);
    check("c_no_req_at_redirect", imem_req, 0);
    cyc(); redirect = 1'b0; gnt_fix = 1'b1; ins_ready = 1'b1;
    @(negedge clk);
    check("c_flushed", ins_valid, 0);
    check("c_req_after", imem_req, 1);
    check("c_addr_after", imem_addr, 32'h100);
    wait_valid("c_wait");
    check("c_first_pc", ins_pc, 32'h100);
    check("c_first_ins", ins, memf(32'h100));

    // Redirect to an unaligned target while a response and a pop coincide.
    lat = 1;
    repeat (10) cyc();
    redirect = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    check("d_valid_at_redirect", ins_valid, 1);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    check("d_flushed", ins_valid, 0);
    wait_valid("d_wait");
    check("d_first_pc", ins_pc, 32'h200);
    check("d_first_ins", ins, memf(32'h200));

    // Fetch PC wraps past the top of the address space.
    cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc(); redirect = 1'b0;
    wait_valid("e_wait");
    check("e_pc0", ins_pc, 32'hFFFF_FFF8);
    cyc(); @(negedge clk);
    check("e_valid1", ins_valid, 1);
    check("e_pc1", ins_pc, 32'hFFFF_FFFC);
    cyc(); @(negedge clk);
    check("e_valid2", ins_valid, 1);
    check("e_pc2", ins_pc, 32'h0000_0000);

    // Reset with requests outstanding; stray responses arrive around the release.
    lat = 3;
    repeat (10) cyc();
    rst = 1'b1; stray_n = 3;
    @(negedge clk);
    check("f_rst_req", imem_req, 0);
    check("f_rst_valid", ins_valid, 0);
    cyc();
    cyc(); rst = 1'b0;
    @(negedge clk);
    check("f_req_after", imem_req, 1);
    check("f_addr_after", imem_addr, RESET_PC);
    wait_valid("f_wait");
    check("f_first_pc", ins_pc, RESET_PC);
    check("f_first_ins", ins, memf(RESET_PC));

    // Random grants, latencies, consumer stalls, redirects and occasional resets.
    gnt_rand = 1; lat_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      ins_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      rst         = ($urandom_range(0, 499) == 0);
    end
    cyc();
    rst = 1'b0; redirect = 1'b0; ins_ready = 1'b1;
    repeat (20) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
